// File: rtl/riscv_store_checker_if.sv
// rtl/riscv_store_checker_if.sv - store port, log reader and status bundle of the store checker
// master = core/testbench side, slave = checker side.
interface riscv_store_checker_if #(
  parameter int Width = 32,
  parameter int DEPTH = 8
);
  logic                     MemWriteM;
  logic [Width-1:0]         ALUResultM;
  logic [Width-1:0]         WriteDataM;
  logic                     log_pop;
  logic                     log_valid;
  logic [Width-1:0]         log_addr;
  logic [Width-1:0]         log_data;
  logic [$clog2(DEPTH):0]   log_count;
  logic                     log_ovf;
  logic [15:0]              store_cnt;
  logic                     done;
  logic                     pass;
  logic                     fail;
  logic                     timeout;

  modport master (
    output MemWriteM, ALUResultM, WriteDataM, log_pop,
    input  log_valid, log_addr, log_data, log_count, log_ovf,
    input  store_cnt, done, pass, fail, timeout
  );

  modport slave (
    input  MemWriteM, ALUResultM, WriteDataM, log_pop,
    output log_valid, log_addr, log_data, log_count, log_ovf,
    output store_cnt, done, pass, fail, timeout
  );
endinterface

// File: rtl/riscv_store_checker.sv
// rtl/riscv_store_checker.sv - store-port monitor with show-ahead log FIFO and pass/fail/timeout FSM
// A program passes by storing PASS_DATA to PASS_ADDR; any other value there fails it.
module riscv_store_checker #(
  parameter int Width     = 32,
  parameter int DEPTH     = 8,
  parameter int PASS_ADDR = 100,
  parameter int PASS_DATA = 25,
  parameter int TIMEOUT   = 1000
) (
  input  logic                  clk,
  input  logic                  reset,
  riscv_store_checker_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_PASS = 2'd2;
  localparam logic [1:0] S_FAIL = 2'd3;

  localparam logic [TW-1:0]    TO_LAST   = TW'(TIMEOUT - 1);
  localparam logic [Width-1:0] ADDR_PASS = Width'(PASS_ADDR);
  localparam logic [Width-1:0] DATA_PASS = Width'(PASS_DATA);
  localparam logic [CW-1:0]    FULL_CNT  = CW'(DEPTH);

  logic [1:0]       r_state;
  logic [TW-1:0]    r_cyc;
  logic             r_timeout;
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [CW-1:0]    r_count;
  logic             r_ovf;
  logic [15:0]      r_store_cnt;
  logic [Width-1:0] r_addr_mem [DEPTH];
  logic [Width-1:0] r_data_mem [DEPTH];

  logic w_store, w_term, w_good, w_expire;
  logic w_full, w_pop, w_push;

  assign w_store  = (r_state == S_RUN) && bus.MemWriteM;
  assign w_term   = w_store && (bus.ALUResultM == ADDR_PASS);
  assign w_good   = w_term && (bus.WriteDataM == DATA_PASS);
  assign w_expire = (r_cyc == TO_LAST) && !w_term;

  // A pop frees a slot in the same cycle, so push+pop on a full log is lossless.
  assign w_full = (r_count == FULL_CNT);
  assign w_pop  = bus.log_pop && (r_count != '0);
  assign w_push = w_store && (!w_full || w_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cyc     <= '0;
      r_timeout <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_state <= S_RUN;
          r_cyc   <= '0;
        end
        S_RUN: begin
          r_cyc <= r_cyc + 1'b1;
          if (w_term) begin
            r_state <= w_good ? S_PASS : S_FAIL;
          end else if (w_expire) begin
            r_state   <= S_FAIL;
            r_timeout <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr        <= '0;
      r_rd        <= '0;
      r_count     <= '0;
      r_ovf       <= 1'b0;
      r_store_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
      if (w_store && !w_push) r_ovf <= 1'b1;
      if (w_store && (r_store_cnt != 16'hFFFF)) r_store_cnt <= r_store_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr_mem[r_wr] <= bus.ALUResultM;
      r_data_mem[r_wr] <= bus.WriteDataM;
    end
  end

  assign bus.log_valid = (r_count != '0);
  assign bus.log_addr  = r_addr_mem[r_rd];
  assign bus.log_data  = r_data_mem[r_rd];
  assign bus.log_count = r_count;
  assign bus.log_ovf   = r_ovf;
  assign bus.store_cnt = r_store_cnt;
  assign bus.pass      = (r_state == S_PASS);
  assign bus.fail      = (r_state == S_FAIL);
  assign bus.done      = (r_state == S_PASS) || (r_state == S_FAIL);
  assign bus.timeout   = r_timeout;

endmodule

// File: tb/tb_riscv_store_checker.sv
// tb/tb_riscv_store_checker.sv - directed bench for riscv_store_checker
// Inputs change and outputs are checked on the falling edge; u_to uses TIMEOUT=16.
module tb_riscv_store_checker;

  logic clk = 1'b0;
  logic rst;
  logic rst_to;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  riscv_store_checker_if #(.Width(32), .DEPTH(8)) bus ();
  riscv_store_checker_if #(.Width(32), .DEPTH(8)) bus_to ();

  riscv_store_checker #(.Width(32), .DEPTH(8), .PASS_ADDR(100), .PASS_DATA(25), .TIMEOUT(1000))
    u_dut (.clk(clk), .reset(rst), .bus(bus));

  riscv_store_checker #(.Width(32), .DEPTH(8), .PASS_ADDR(100), .PASS_DATA(25), .TIMEOUT(16))
    u_to (.clk(clk), .reset(rst_to), .bus(bus_to));

  typedef struct {
    logic        mw;
    logic [31:0] addr;
    logic [31:0] data;
    logic        pop;
    logic        exp_valid;
    logic [31:0] exp_addr;
    logic [31:0] exp_data;
    int          exp_count;
    logic        exp_pass;
    logic        exp_fail;
    int          exp_cnt;
  } vec_t;

  vec_t vt[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  // Drive one cycle on the main DUT; returns on the next falling edge with inputs idle.
  task automatic cyc(input logic mw, input logic [31:0] a, input logic [31:0] d, input logic p);
    bus.MemWriteM  = mw;
    bus.ALUResultM = a;
    bus.WriteDataM = d;
    bus.log_pop    = p;
    @(negedge clk);
    bus.MemWriteM  = 1'b0;
    bus.log_pop    = 1'b0;
  endtask

  task automatic reset_main(input int n);
    rst = 1'b1;
    repeat (n) @(negedge clk);
    rst = 1'b0;
    cyc(1'b0, 0, 0, 1'b0);
  endtask

  task automatic reset_to();
    rst_to = 1'b1;
    bus_to.MemWriteM = 1'b0;
    bus_to.log_pop   = 1'b0;
    repeat (3) @(negedge clk);
    rst_to = 1'b0;
    repeat (16) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    rst_to = 1'b1;
    bus.MemWriteM = 1'b0; bus.ALUResultM = '0; bus.WriteDataM = '0; bus.log_pop = 1'b0;
    bus_to.MemWriteM = 1'b0; bus_to.ALUResultM = '0; bus_to.WriteDataM = '0; bus_to.log_pop = 1'b0;

    vt[0] = '{1'b1, 32'd4,   32'd7,  1'b0, 1'b1, 32'd4,   32'd7,  1, 1'b0, 1'b0, 1};
    vt[1] = '{1'b1, 32'd8,   32'd3,  1'b0, 1'b1, 32'd4,   32'd7,  2, 1'b0, 1'b0, 2};
    vt[2] = '{1'b1, 32'd100, 32'd25, 1'b0, 1'b1, 32'd4,   32'd7,  3, 1'b1, 1'b0, 3};
    vt[3] = '{1'b1, 32'd100, 32'd24, 1'b0, 1'b1, 32'd4,   32'd7,  3, 1'b1, 1'b0, 3};
    vt[4] = '{1'b0, 32'd0,   32'd0,  1'b1, 1'b1, 32'd8,   32'd3,  2, 1'b1, 1'b0, 3};
    vt[5] = '{1'b0, 32'd0,   32'd0,  1'b1, 1'b1, 32'd100, 32'd25, 1, 1'b1, 1'b0, 3};
    vt[6] = '{1'b0, 32'd0,   32'd0,  1'b1, 1'b0, 32'd0,   32'd0,  0, 1'b1, 1'b0, 3};
    vt[7] = '{1'b0, 32'd0,   32'd0,  1'b1, 1'b0, 32'd0,   32'd0,  0, 1'b1, 1'b0, 3};

    // Reset state, then a store during the IDLE cycle must be ignored.
    repeat (20) @(negedge clk);
    chk("rst_valid", 32'(bus.log_valid), 0);
    chk("rst_count", 32'(bus.log_count), 0);
    chk("rst_done",  32'(bus.done), 0);
    chk("rst_cnt",   32'(bus.store_cnt), 0);
    chk("rst_ovf",   32'(bus.log_ovf), 0);
    rst = 1'b0;
    cyc(1'b1, 32'd200, 32'd1, 1'b0);
    chk("idle_ignore_count", 32'(bus.log_count), 0);
    chk("idle_ignore_cnt",   32'(bus.store_cnt), 0);

    for (int i = 0; i < 8; i++) begin
      cyc(vt[i].mw, vt[i].addr, vt[i].data, vt[i].pop);
      chk($sformatf("v%0d_valid", i), 32'(bus.log_valid), 32'(vt[i].exp_valid));
      if (vt[i].exp_valid) begin
        chk($sformatf("v%0d_addr", i), bus.log_addr, vt[i].exp_addr);
        chk($sformatf("v%0d_data", i), bus.log_data, vt[i].exp_data);
      end
      chk($sformatf("v%0d_count", i), 32'(bus.log_count), 32'(vt[i].exp_count));
      chk($sformatf("v%0d_pass", i),  32'(bus.pass), 32'(vt[i].exp_pass));
      chk($sformatf("v%0d_fail", i),  32'(bus.fail), 32'(vt[i].exp_fail));
      chk($sformatf("v%0d_cnt", i),   32'(bus.store_cnt), 32'(vt[i].exp_cnt));
    end

    // Wrong data at PASS_ADDR fails; later stores are ignored.
    reset_main(2);
    cyc(1'b1, 32'd100, 32'd24, 1'b0);
    chk("bad_fail", 32'(bus.fail), 1);
    chk("bad_pass", 32'(bus.pass), 0);
    chk("bad_done", 32'(bus.done), 1);
    chk("bad_timeout", 32'(bus.timeout), 0);
    cyc(1'b1, 32'd100, 32'd25, 1'b0);
    chk("bad_after_fail", 32'(bus.fail), 1);
    chk("bad_after_pass", 32'(bus.pass), 0);
    chk("bad_after_cnt",  32'(bus.store_cnt), 1);

    // Fill, push+pop while full, overflow, drain, wrap.
    reset_main(2);
    for (int i = 1; i <= 8; i++) cyc(1'b1, 32'(i), 32'(i + 10), 1'b0);
    chk("full_count", 32'(bus.log_count), 8);
    chk("full_ovf",   32'(bus.log_ovf), 0);
    cyc(1'b1, 32'd9, 32'd19, 1'b1);
    chk("pp_count", 32'(bus.log_count), 8);
    chk("pp_ovf",   32'(bus.log_ovf), 0);
    chk("pp_head",  bus.log_addr, 2);
    cyc(1'b1, 32'd10, 32'd20, 1'b0);
    cyc(1'b1, 32'd11, 32'd21, 1'b0);
    chk("ovf_count", 32'(bus.log_count), 8);
    chk("ovf_flag",  32'(bus.log_ovf), 1);
    chk("ovf_cnt",   32'(bus.store_cnt), 11);
    chk("ovf_head",  bus.log_data, 12);
    for (int i = 2; i <= 9; i++) begin
      chk($sformatf("drain%0d_valid", i), 32'(bus.log_valid), 1);
      chk($sformatf("drain%0d_addr", i),  bus.log_addr, 32'(i));
      chk($sformatf("drain%0d_data", i),  bus.log_data, 32'(i + 10));
      cyc(1'b0, 0, 0, 1'b1);
    end
    chk("drain_valid", 32'(bus.log_valid), 0);
    cyc(1'b0, 0, 0, 1'b1);
    chk("extra_pop_count", 32'(bus.log_count), 0);
    chk("extra_pop_ovf",   32'(bus.log_ovf), 1);
    cyc(1'b1, 32'd12, 32'd22, 1'b1);
    chk("wrap_count", 32'(bus.log_count), 1);
    chk("wrap_addr",  bus.log_addr, 12);
    chk("wrap_data",  bus.log_data, 22);

    // Asynchronous reset mid-RUN.
    reset_main(2);
    cyc(1'b1, 32'd1, 32'd2, 1'b0);
    cyc(1'b1, 32'd3, 32'd4, 1'b0);
    cyc(1'b1, 32'd5, 32'd6, 1'b0);
    chk("mid_pre_count", 32'(bus.log_count), 3);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_valid", 32'(bus.log_valid), 0);
    chk("mid_cnt",   32'(bus.store_cnt), 0);
    chk("mid_pass",  32'(bus.pass), 0);
    chk("mid_fail",  32'(bus.fail), 0);
    @(negedge clk);
    rst = 1'b0;
    cyc(1'b0, 0, 0, 1'b0);
    cyc(1'b1, 32'd100, 32'd25, 1'b0);
    chk("mid_repass", 32'(bus.pass), 1);
    chk("mid_recount", 32'(bus.log_count), 1);
    chk("mid_rehead", bus.log_data, 25);

    // Timeout: fail exactly at the 16th RUN edge; a pass store at cycle 15 wins instead.
    reset_to();
    chk("to_before", 32'(bus_to.fail), 0);
    @(negedge clk);
    chk("to_fail",    32'(bus_to.fail), 1);
    chk("to_timeout", 32'(bus_to.timeout), 1);
    chk("to_done",    32'(bus_to.done), 1);
    repeat (3) @(negedge clk);
    chk("to_sticky", 32'(bus_to.timeout), 1);
    reset_to();
    bus_to.MemWriteM = 1'b1; bus_to.ALUResultM = 32'd100; bus_to.WriteDataM = 32'd25;
    @(negedge clk);
    bus_to.MemWriteM = 1'b0;
    chk("to_race_pass",    32'(bus_to.pass), 1);
    chk("to_race_fail",    32'(bus_to.fail), 0);
    chk("to_race_timeout", 32'(bus_to.timeout), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
